// File: rtl/ecore_gpio.sv
// Memory-mapped GPIO responder for the ecore data-memory port: eight-word register
// window, one-cycle acknowledge, synchronised pin edge capture and level interrupt.
module ecore_gpio #(
  parameter logic [29:0] BASE_WORD   = 30'h0400_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [29:0] i_addr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_irq,
  inout  wire  [31:0] io_gpio_bank
);
  localparam int unsigned        PRIME_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

  typedef enum logic {S_IDLE, S_ACK} state_t;
  typedef enum logic [2:0] {R_OUT, R_DIR, R_IN, R_RISE, R_FALL, R_IEN, R_SET, R_CLR} reg_t;

  state_t state_q, state_d;
  reg_t   off;
  logic   hit;
  logic [31:0] bmask, wmask;
  logic [31:0] out_q, dir_q, ien_q, rise_q, fall_q;
  logic [31:0] out_d, dir_d, ien_d, rise_d, fall_d, rdata_d;
  logic        ack_d, err_d;
  logic [SYNC_STAGES-1:0][31:0] sync_q;
  logic [31:0] sync_w, prev_q, rise_set, fall_set;
  logic [PRIME_W-1:0] prime_q;

  assign off      = reg_t'(i_addr[2:0]);
  assign hit      = (i_addr[29:3] == BASE_WORD[29:3]);
  assign bmask    = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
  assign wmask    = i_wdata & bmask;
  assign sync_w   = sync_q[SYNC_STAGES-1];
  // Capture is held off until the synchroniser and prev have flushed out of reset,
  // so pins already high at reset never look like a rising edge.
  assign rise_set = (prime_q == PRIME_DONE) ? (sync_w & ~prev_q) : '0;
  assign fall_set = (prime_q == PRIME_DONE) ? (~sync_w & prev_q) : '0;

  for (genvar g = 0; g < 32; g++) begin : g_pin
    assign io_gpio_bank[g] = dir_q[g] ? out_q[g] : 1'bz;
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    out_d   = out_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (!hit) begin
            err_d = 1'b1;
          end else begin
            case (off)
              R_OUT:   rdata_d = out_q;
              R_DIR:   rdata_d = dir_q;
              R_IN:    rdata_d = sync_w;
              R_RISE:  rdata_d = rise_q;
              R_FALL:  rdata_d = fall_q;
              R_IEN:   rdata_d = ien_q;
              R_SET:   rdata_d = '0;
              R_CLR:   rdata_d = '0;
              default: rdata_d = '0;
            endcase
            if (i_we) begin
              case (off)
                R_OUT:   out_d  = (out_q & ~bmask) | wmask;
                R_DIR:   dir_d  = (dir_q & ~bmask) | wmask;
                R_RISE:  rise_d = rise_q & ~wmask;
                R_FALL:  fall_d = fall_q & ~wmask;
                R_IEN:   ien_d  = (ien_q & ~bmask) | wmask;
                R_SET:   out_d  = out_q | wmask;
                R_CLR:   out_d  = out_q & ~wmask;
                default: out_d  = out_q;
              endcase
            end
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // New edges are ORed in after the W1C so a coincident set survives the clear.
    rise_d = rise_d | rise_set;
    fall_d = fall_d | fall_set;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      prime_q <= '0;
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      o_irq   <= 1'b0;
      o_rdata <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], io_gpio_bank};
      prev_q  <= sync_w;
      if (prime_q != PRIME_DONE) prime_q <= prime_q + PRIME_W'(1);
      o_ack   <= ack_d;
      o_err   <= err_d;
      o_irq   <= |((rise_q | fall_q) & ien_q);
      o_rdata <= rdata_d;
    end
  end
endmodule

// File: tb/tb_ecore_gpio.sv
// Randomised scoreboard bench for ecore_gpio: a pin-history reference model predicts
// each acknowledged response, the interrupt level and the driven pins.
module tb_ecore_gpio;
  localparam logic [29:0] BASE = 30'h0400_0000;
  localparam int          SS   = 2;

  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_req = 1'b0, i_we = 1'b0;
  logic [29:0] i_addr = '0;
  logic [3:0]  i_be = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_ack, o_err, o_irq;
  wire  [31:0] pins;
  logic [31:0] tb_drv = '1, tb_en = '1;

  for (genvar g = 0; g < 32; g++) begin : g_drv
    assign pins[g] = tb_en[g] ? tb_drv[g] : 1'bz;
  end

  ecore_gpio #(.BASE_WORD(BASE), .SYNC_STAGES(SS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_be(i_be), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_ack(o_ack), .o_err(o_err),
    .o_irq(o_irq), .io_gpio_bank(pins)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0, n_err = 0, cyc = 0, last_ack = -100;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_prev_ack = 1'b0;

  // Reference model: registers as plain words, pins as a history of sampled levels.
  logic [31:0] m_out = '0, m_dir = '0, m_ien = '0, m_rise = '0, m_fall = '0;
  logic        m_irq = 1'b0, m_busy = 1'b0;
  int          m_edges = 0, mp_off;
  logic [31:0] hist[$];
  logic [31:0] mp_pin, mp_sync, mp_prev, mp_rs, mp_fs, mp_bm, mp_wm, mp_rd;

  task automatic fail(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_err++;
    $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) fail(name, got, exp);
  endtask

  initial forever begin
    @(posedge i_clk or negedge i_rst_n);
    if (!i_rst_n) begin
      m_out = '0; m_dir = '0; m_ien = '0; m_rise = '0; m_fall = '0;
      m_irq = 1'b0; m_busy = 1'b0; m_edges = 0;
      exp_q.delete();
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back('0);
      tb_en <= '1;
    end else begin
      mp_pin  = (m_dir & m_out) | (~m_dir & tb_drv);
      mp_sync = hist[SS-1];
      mp_prev = hist[SS];
      if (m_edges < 1000) m_edges++;
      mp_rs = (m_edges >= SS + 2) ? (mp_sync & ~mp_prev) : '0;
      mp_fs = (m_edges >= SS + 2) ? (~mp_sync & mp_prev) : '0;
      m_irq = |((m_rise | m_fall) & m_ien);
      if (i_req && !m_busy) begin
        m_busy = 1'b1;
        mp_bm  = '0;
        for (int b = 0; b < 4; b++) if (i_be[b]) mp_bm = mp_bm | (32'hFF << (8 * b));
        mp_wm  = i_wdata & mp_bm;
        mp_off = int'(i_addr) - int'(BASE);
        if (mp_off < 0 || mp_off > 7) begin
          exp_q.push_back('{rdata: 32'h0, err: 1'b1});
        end else begin
          case (mp_off)
            0: mp_rd = m_out;
            1: mp_rd = m_dir;
            2: mp_rd = mp_sync;
            3: mp_rd = m_rise;
            4: mp_rd = m_fall;
            5: mp_rd = m_ien;
            default: mp_rd = '0;
          endcase
          exp_q.push_back('{rdata: mp_rd, err: 1'b0});
          if (i_we) begin
            case (mp_off)
              0: m_out  = (m_out & ~mp_bm) | mp_wm;
              1: m_dir  = (m_dir & ~mp_bm) | mp_wm;
              3: m_rise = m_rise & ~mp_wm;
              4: m_fall = m_fall & ~mp_wm;
              5: m_ien  = (m_ien & ~mp_bm) | mp_wm;
              6: m_out  = m_out | mp_wm;
              7: m_out  = m_out & ~mp_wm;
              default: ;
            endcase
          end
        end
      end else begin
        m_busy = 1'b0;
      end
      m_rise = m_rise | mp_rs;
      m_fall = m_fall | mp_fs;
      hist.push_front(mp_pin);
      void'(hist.pop_back());
      tb_en <= ~m_dir;
    end
  end

  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      check("reset_outputs", {o_ack, o_err, o_irq, o_rdata}, 64'h0);
    end else begin
      check("irq_level", o_irq, m_irq);
      if (o_ack) begin
        check("ack_width", mon_prev_ack, 1'b0);
        n_vec++;
        if (exp_q.size() == 0) begin
          fail("spurious_ack", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rdata", o_rdata, mon_e.rdata);
          check("err", o_err, mon_e.err);
        end
      end else begin
        check("idle_outputs", {o_err, o_rdata}, 64'h0);
      end
      if (m_dir != 0) check("pin_drive", pins & m_dir, m_out & m_dir);
    end
    mon_prev_ack = o_ack;
  end

  task automatic xfer(input logic we, input logic [29:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input bit chk_rate, output logic [31:0] rdv);
    bit got = 0;
    i_req = 1'b1; i_we = we; i_addr = addr; i_be = be; i_wdata = wd;
    rdv = '0;
    for (int n = 0; n < 6 && !got; n++) begin
      @(negedge i_clk);
      if (o_ack) begin got = 1; rdv = o_rdata; end
    end
    i_req = 1'b0; i_we = 1'b0;
    n_vec++;
    if (!got) fail("ack_timeout", 0, 1);
    else if (chk_rate) check("b2b_rate", 64'(cyc - last_ack), 64'd2);
    last_ack = cyc;
  endtask

  task automatic wr(input int off, input logic [31:0] d, input logic [3:0] be = 4'hF,
                    input bit chk_rate = 0);
    logic [31:0] dummy;
    xfer(1'b1, 30'(int'(BASE) + off), be, d, chk_rate, dummy);
  endtask

  task automatic rd(input int off, output logic [31:0] d, input bit chk_rate = 0);
    xfer(1'b0, 30'(int'(BASE) + off), 4'hF, '0, chk_rate, d);
  endtask

  initial begin
    logic [31:0] d;
    logic [29:0] a;
    int lat, r;
    bit found;

    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    rd(2, d); check("in_after_reset", d, 32'hFFFF_FFFF);
    rd(3, d); check("rise_after_reset", d, 32'h0);
    rd(4, d); rd(0, d); rd(1, d); rd(5, d);

    tb_drv = '0;
    repeat (5) @(negedge i_clk);
    wr(1, 32'h0000_00FF);
    wr(0, 32'hA5A5_A5A5);
    @(negedge i_clk);
    check("pins_low_byte", pins[7:0], 8'hA5);
    wr(6, 32'h0000_0100); rd(0, d); check("out_after_set", d, 32'hA5A5_A5A5);
    wr(7, 32'h0000_0005); rd(0, d); check("out_after_clr", d, 32'hA5A5_A5A0);

    wr(0, 32'h0);
    wr(0, 32'hFFFF_FFFF, 4'b0010, 1);
    rd(0, d, 1); check("out_byte_lane", d, 32'h0000_FF00);
    wr(0, 32'hFFFF_FFFF, 4'b0000, 1);
    rd(0, d); check("out_be_zero", d, 32'h0000_FF00);

    wr(1, 32'h0);
    repeat (6) @(negedge i_clk);
    wr(3, 32'hFFFF_FFFF); wr(4, 32'hFFFF_FFFF); wr(5, 32'h0000_0008);
    tb_drv[3] = 1'b1;
    lat = 0; found = 0;
    for (int k = 1; k <= 8 && !found; k++) begin
      @(negedge i_clk);
      if (o_irq) begin found = 1; lat = k; end
    end
    check("irq_latency", 64'(lat), 64'd4);
    rd(3, d); check("rise_captured", d, 32'h8);
    wr(3, 32'h8);
    check("irq_before_clear", o_irq, 1'b1);
    @(negedge i_clk);
    check("irq_after_clear", o_irq, 1'b0);

    tb_drv[3] = 1'b0;
    repeat (6) @(negedge i_clk);
    wr(4, 32'h8);
    tb_drv[3] = 1'b1;
    repeat (2) @(negedge i_clk);
    wr(3, 32'h8);
    rd(3, d); check("rise_set_wins", d, 32'h8);

    xfer(1'b0, BASE + 30'd8, 4'hF, '0, 0, d);
    xfer(1'b0, BASE - 30'd1, 4'hF, '0, 0, d);
    xfer(1'b1, BASE + 30'd8, 4'hF, 32'hFFFF_FFFF, 0, d);
    xfer(1'b1, BASE - 30'd1, 4'hF, 32'hFFFF_FFFF, 0, d);
    rd(0, d); check("out_after_miss", d, 32'h0000_FF00);

    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r == 8) a = 30'(int'(BASE) + 8 + int'($urandom_range(0, 100)));
      else if (r == 9) a = 30'(int'(BASE) - 1 - int'($urandom_range(0, 100)));
      else a = 30'(int'(BASE) + r);
      if ($urandom_range(0, 3) == 0) tb_drv = tb_drv ^ $urandom();
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom(), 0, d);
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end

    wr(1, 32'hFFFF_0000); wr(0, 32'h1234_5678); wr(5, 32'hFFFF_FFFF);
    i_req = 1'b1; i_we = 1'b1; i_addr = BASE; i_be = 4'hF; i_wdata = '1;
    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    i_req = 1'b0; i_we = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    rd(0, d); check("out_after_abort", d, 32'h0);
    rd(1, d); check("dir_after_abort", d, 32'h0);
    rd(5, d); check("ien_after_abort", d, 32'h0);
    rd(3, d); rd(4, d);

    repeat (2) @(negedge i_clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
